// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port multi-cycle main memory between instruction fetch and
// load/store, with req/ack handshake, pipeline stall generation and a no-ack watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              stall_if,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_D = 3'd1;
  localparam logic [2:0] BUSY_I = 3'd2;
  localparam logic [2:0] DONE_D = 3'd3;
  localparam logic [2:0] DONE_I = 3'd4;

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] wd_cnt;
  logic             data_req;
  logic             busy;
  logic             in_data;

  assign data_req = mem_read | mem_write;
  assign busy     = (state == BUSY_D) || (state == BUSY_I);
  assign in_data  = (state == BUSY_D);

  // Stalls are combinational so a stage freezes in the very cycle it requests;
  // they release only in the DONE cycle, where the pipeline advances.
  assign stall_mem = data_req & (state != DONE_D);
  assign stall_if  = stall_mem | (if_req & (state != DONE_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      mem_rdata <= '0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= mem_write;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            wd_cnt  <= '0;
            // Read and write together: the write wins, the conflict is flagged.
            if (mem_read && mem_write) begin
              bus_err <= 1'b1;
            end
          end else if (if_req) begin
            state  <= BUSY_I;
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= if_addr;
            wd_cnt <= '0;
          end
        end
        BUSY_D, BUSY_I: begin
          if (m_ack) begin
            m_req <= 1'b0;
            if (in_data) begin
              state     <= DONE_D;
              mem_rdata <= m_rdata;
              mem_ready <= 1'b1;
            end else begin
              state    <= DONE_I;
              if_rdata <= m_rdata;
              if_ready <= 1'b1;
            end
          end else if (wd_cnt == CNT_LAST) begin
            // Abort still completes the access so the stalled stage can move on.
            m_req   <= 1'b0;
            bus_err <= 1'b1;
            if (in_data) begin
              state     <= DONE_D;
              mem_rdata <= '0;
              mem_ready <= 1'b1;
            end else begin
              state    <= DONE_I;
              if_rdata <= '0;
              if_ready <= 1'b1;
            end
          end else if (busy) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE_D, DONE_I: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-plus-random bench for mem_port_arbiter; expected timing comes from a
// transaction-level schedule (start cycle, ack delay, watchdog limit).
module tb_mem_port_arbiter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        stall_if;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        bus_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  bit berr   = 1'b0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .stall_if(stall_if),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_req    = 1'b0;
    m_ack     = 1'b0;
  endtask

  // Entered at posedge+1 of a cycle with the arbiter in IDLE; leaves it the same way.
  // dd/di are the m_req cycles the memory lets pass before acking (>= TO means never).
  task automatic run_scn(input string tag, input bit rd, input bit wr,
                         input logic [31:0] maddr, input logic [31:0] wdat,
                         input bit fq, input logic [31:0] faddr,
                         input int dd, input int di);
    bit has_d, tod, toi, mq_d, mq_i, dq, iq, sm_exp, be_exp;
    int ld, li, rdy_d, s_i, rdy_i, last;
    logic [31:0] dval, ival;
    has_d = rd | wr;
    tod   = has_d && (dd >= TO);
    toi   = fq && (di >= TO);
    ld    = (dd >= TO) ? TO - 1 : dd;
    li    = (di >= TO) ? TO - 1 : di;
    rdy_d = has_d ? ld + 2 : -1;
    s_i   = has_d ? ld + 3 : 0;
    rdy_i = fq ? s_i + li + 2 : -1;
    last  = fq ? rdy_i : rdy_d;
    dval  = $urandom;
    ival  = $urandom;
    for (int c = 0; c <= last; c++) begin
      dq   = has_d && (c <= rdy_d);
      iq   = fq && (c <= rdy_i);
      mq_d = has_d && (c >= 1) && (c <= 1 + ld);
      mq_i = fq && (c >= s_i + 1) && (c <= s_i + 1 + li);
      mem_read  = rd & dq;
      mem_write = wr & dq;
      mem_addr  = dq ? maddr : $urandom;
      mem_wdata = dq ? wdat : $urandom;
      if_req    = iq;
      if_addr   = iq ? faddr : $urandom;
      if (has_d && !tod && c == 1 + ld) begin
        m_ack = 1'b1; m_rdata = dval;
      end else if (fq && !toi && c == s_i + 1 + li) begin
        m_ack = 1'b1; m_rdata = ival;
      end else begin
        m_ack   = !(mq_d || mq_i) && ($urandom_range(0, 2) == 0);
        m_rdata = $urandom;
      end
      #1;
      sm_exp = dq && (c != rdy_d);
      be_exp = berr | ((rd && wr) && c >= 1) | (tod && c >= rdy_d) | (toi && c >= rdy_i);
      chk($sformatf("%s.m_req@%0d", tag, c), m_req, mq_d | mq_i);
      if (mq_d) begin
        chk($sformatf("%s.m_we@%0d", tag, c), m_we, wr);
        chk($sformatf("%s.m_addr@%0d", tag, c), m_addr, maddr);
        if (wr) chk($sformatf("%s.m_wdata@%0d", tag, c), m_wdata, wdat);
      end
      if (mq_i) begin
        chk($sformatf("%s.m_we_if@%0d", tag, c), m_we, 1'b0);
        chk($sformatf("%s.m_addr_if@%0d", tag, c), m_addr, faddr);
      end
      chk($sformatf("%s.mem_ready@%0d", tag, c), mem_ready, has_d && (c == rdy_d));
      if (has_d && c == rdy_d && (tod || !wr))
        chk($sformatf("%s.mem_rdata@%0d", tag, c), mem_rdata, tod ? 32'h0 : dval);
      chk($sformatf("%s.if_ready@%0d", tag, c), if_ready, fq && (c == rdy_i));
      if (fq && c == rdy_i)
        chk($sformatf("%s.if_rdata@%0d", tag, c), if_rdata, toi ? 32'h0 : ival);
      chk($sformatf("%s.stall_mem@%0d", tag, c), stall_mem, sm_exp);
      chk($sformatf("%s.stall_if@%0d", tag, c), stall_if, sm_exp | (iq && (c != rdy_i)));
      chk($sformatf("%s.bus_err@%0d", tag, c), bus_err, be_exp);
      @(posedge clk);
      #1;
    end
    berr = berr | (rd & wr) | tod | toi;
    idle_inputs();
  endtask

  initial begin
    int kind;
    logic [31:0] a, w, f;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.m_req", m_req, 1'b0);
    chk("rst.m_we", m_we, 1'b0);
    chk("rst.m_addr", m_addr, 32'h0);
    chk("rst.m_wdata", m_wdata, 32'h0);
    chk("rst.mem_ready", mem_ready, 1'b0);
    chk("rst.if_ready", if_ready, 1'b0);
    chk("rst.mem_rdata", mem_rdata, 32'h0);
    chk("rst.if_rdata", if_rdata, 32'h0);
    chk("rst.bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait load, then simultaneous write+fetch, then wait states
    run_scn("load0", 1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 0);
    run_scn("simul", 0, 1, 32'h200, 32'h12345678, 1, 32'h40, 1, 2);
    run_scn("wait_rd", 1, 0, 32'h104, 32'h0, 0, 32'h0, 5, 0);
    run_scn("wait_wr", 0, 1, 32'h108, 32'hCAFEF00D, 0, 32'h0, 5, 0);
    run_scn("wait_if", 0, 0, 32'h0, 32'h0, 1, 32'h44, 0, 5);
    run_scn("edge63", 1, 0, 32'h10C, 32'h0, 0, 32'h0, TO - 1, 0);

    // Randomized mix of loads, stores and fetches (no conflicts)
    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 4);
      a = $urandom; w = $urandom; f = $urandom;
      run_scn($sformatf("rnd%0d", n), kind == 0 || kind == 3, kind == 1 || kind == 4, a, w,
              kind >= 2, f, $urandom_range(0, 6), $urandom_range(0, 6));
    end

    // Watchdog abort on a load, then bus_err must stay set
    run_scn("tmo_rd", 1, 0, 32'h300, 32'h0, 0, 32'h0, 1000, 0);
    run_scn("tmo_if", 0, 0, 32'h0, 32'h0, 1, 32'h48, 0, 1000);
    run_scn("sticky", 0, 1, 32'h304, 32'h55AA55AA, 1, 32'h4C, 2, 0);

    // Reset during BUSY_D
    mem_read = 1'b1;
    mem_addr = 32'h380;
    @(posedge clk);
    #1;
    chk("midrst.m_req_before", m_req, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.m_req", m_req, 1'b0);
    chk("midrst.m_addr", m_addr, 32'h0);
    chk("midrst.bus_err", bus_err, 1'b0);
    chk("midrst.mem_ready", mem_ready, 1'b0);
    chk("midrst.if_rdata", if_rdata, 32'h0);
    idle_inputs();
    berr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_scn("postrst", 0, 0, 32'h0, 32'h0, 1, 32'h80, 2, 3);

    // Read/write conflict: write performed, error flagged
    run_scn("conflict", 1, 1, 32'h400, 32'hA5A5A5A5, 0, 32'h0, 3, 0);
    run_scn("after", 1, 0, 32'h404, 32'h0, 1, 32'h84, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
